// File: rtl/placar_bcd_pkg.sv
// Shared types and BCD helpers for the placar_bcd scoreboard.
// Contents:
//   - state_e      : game FSM states (idle, playing, game over)
//   - bcd_t        : one BCD digit
//   - bcd_num_t    : score-sized BCD number, MAX_DIGITS wide, units in [0]
//   - lives_t      : two-digit BCD lives counter
//   - SEG_BLANK    : active-low blank segment pattern
//   - bcd_inc/bcd_gt/lives_inc_sat/lives_dec : ripple BCD arithmetic, no binary conversion
package placar_pkg;

  localparam int unsigned MAX_DIGITS = 6;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [3:0] bcd_t;
  typedef bcd_t [MAX_DIGITS-1:0] bcd_num_t;
  typedef bcd_t [1:0] lives_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StOver = 2'd2
  } state_e;

  // Result of a saturating score increment; carry_in[i] marks a ripple carry into digit i.
  typedef struct packed {
    bcd_num_t              value;
    logic [MAX_DIGITS-1:0] carry_in;
    logic                  sat;
  } bcd_inc_t;

  // Elaboration-time only: turns a parameter into a two-digit BCD constant.
  function automatic lives_t to_bcd2(input int unsigned v);
    lives_t r;
    r[1] = bcd_t'((v / 10) % 10);
    r[0] = bcd_t'(v % 10);
    return r;
  endfunction

  // Add one to the low n digits; all-nines stays all-nines.
  function automatic bcd_inc_t bcd_inc(input bcd_num_t v, input int n);
    bcd_inc_t r;
    logic     c;
    r.value    = v;
    r.carry_in = '0;
    r.sat      = 1'b1;
    for (int i = 0; i < int'(MAX_DIGITS); i++) begin
      if (i < n && v[i] != 4'd9) r.sat = 1'b0;
    end
    if (!r.sat) begin
      c = 1'b1;
      for (int i = 0; i < int'(MAX_DIGITS); i++) begin
        if (i < n && c) begin
          r.carry_in[i] = (i > 0);
          if (v[i] == 4'd9) begin
            r.value[i] = 4'd0;
          end else begin
            r.value[i] = v[i] + 4'd1;
            c          = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Strict greater-than over the low n digits, most significant digit first.
  function automatic logic bcd_gt(input bcd_num_t a, input bcd_num_t b, input int n);
    logic gt;
    logic decided;
    gt      = 1'b0;
    decided = 1'b0;
    for (int k = 0; k < int'(MAX_DIGITS); k++) begin
      int i;
      i = int'(MAX_DIGITS) - 1 - k;
      if (i < n && !decided && a[i] != b[i]) begin
        gt      = (a[i] > b[i]);
        decided = 1'b1;
      end
    end
    return gt;
  endfunction

  function automatic lives_t lives_inc_sat(input lives_t v, input lives_t max_v);
    lives_t r;
    r = v;
    if (v != max_v) begin
      if (v[0] == 4'd9) begin
        r[0] = 4'd0;
        r[1] = v[1] + 4'd1;
      end else begin
        r[0] = v[0] + 4'd1;
      end
    end
    return r;
  endfunction

  // Zero stays zero.
  function automatic lives_t lives_dec(input lives_t v);
    lives_t r;
    r = v;
    if (v[0] != 4'd0) begin
      r[0] = v[0] - 4'd1;
    end else if (v[1] != 4'd0) begin
      r[0] = 4'd9;
      r[1] = v[1] - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/placar_bcd_if.sv
// Game-side bus of the placar_bcd scoreboard.
// Signals (named from the scoreboard's point of view):
//   i_start, i_hit_block, i_endgame, i_show_hi : level inputs from the game logic
//   o_score_seg : 7 bits per score digit, units in [6:0], active-low
//   o_lives_seg : two lives digits, units in [6:0], active-low
//   o_playing, o_game_over : registered state flags
// Modports: master drives the inputs (game/bench), slave is the scoreboard.
interface placar_bcd_if #(
  parameter int unsigned SCORE_DIGITS = 3
);
  logic                      i_start;
  logic                      i_hit_block;
  logic                      i_endgame;
  logic                      i_show_hi;
  logic [7*SCORE_DIGITS-1:0] o_score_seg;
  logic [13:0]               o_lives_seg;
  logic                      o_playing;
  logic                      o_game_over;

  modport master (
    output i_start, i_hit_block, i_endgame, i_show_hi,
    input  o_score_seg, o_lives_seg, o_playing, o_game_over
  );

  modport slave (
    input  i_start, i_hit_block, i_endgame, i_show_hi,
    output o_score_seg, o_lives_seg, o_playing, o_game_over
  );
endinterface

// File: rtl/placar_bcd_seg7_digit.sv
// One BCD digit to active-low seven-segment code (bit0=a .. bit6=g).
// Ports:
//   i_digit : BCD value 0..9 (10..15 show blank)
//   i_blank : force blank
//   o_seg   : active-low segments, 7'h7F = all off
module seg7_digit
  import placar_pkg::*;
(
  input  bcd_t       i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      unique case (i_digit)
        4'd0:    o_seg = 7'h40;
        4'd1:    o_seg = 7'h79;
        4'd2:    o_seg = 7'h24;
        4'd3:    o_seg = 7'h30;
        4'd4:    o_seg = 7'h19;
        4'd5:    o_seg = 7'h12;
        4'd6:    o_seg = 7'h02;
        4'd7:    o_seg = 7'h78;
        4'd8:    o_seg = 7'h00;
        4'd9:    o_seg = 7'h10;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end
endmodule

// File: rtl/placar_bcd.sv
// Breakout-style scoreboard: BCD score, high score and lives with 7-seg outputs.
// Ports:
//   i_clock : single clock, rising edge
//   i_reset : synchronous active-high reset
//   bus     : placar_bcd_if slave (start/hit/endgame/show_hi in, segments and flags out)
// Parameters: SCORE_DIGITS (2..6), LIVES_INIT, LIVES_MAX (<=99), BONUS_DIGIT (0 = no bonus).
module placar_bcd
  import placar_pkg::*;
#(
  parameter int unsigned SCORE_DIGITS = 3,
  parameter int unsigned LIVES_INIT   = 10,
  parameter int unsigned LIVES_MAX    = 99,
  parameter int unsigned BONUS_DIGIT  = 2
) (
  input logic          i_clock,
  input logic          i_reset,
  placar_bcd_if.slave  bus
);
  localparam lives_t      LivesInitBcd = to_bcd2(LIVES_INIT);
  localparam lives_t      LivesMaxBcd  = to_bcd2(LIVES_MAX);
  localparam bit          BonusEn      = (BONUS_DIGIT > 0) && (BONUS_DIGIT < SCORE_DIGITS);
  localparam int unsigned BonusIdx     = BonusEn ? BONUS_DIGIT : 1;

  state_e   r_state;
  bcd_num_t r_score;
  bcd_num_t r_hi;
  lives_t   r_lives;
  logic     r_hit_q;
  logic     r_end_q;
  logic     r_playing;
  logic     r_game_over;

  logic     w_hit_rise;
  logic     w_end_rise;
  bcd_inc_t w_inc;
  lives_t   w_lives_dec;
  lives_t   w_lives_inc;

  assign w_hit_rise  = bus.i_hit_block & ~r_hit_q;
  assign w_end_rise  = bus.i_endgame & ~r_end_q;
  assign w_inc       = bcd_inc(r_score, int'(SCORE_DIGITS));
  assign w_lives_dec = lives_dec(r_lives);
  assign w_lives_inc = lives_inc_sat(r_lives, LivesMaxBcd);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_score     <= '0;
      r_hi        <= '0;
      r_lives     <= LivesInitBcd;
      r_hit_q     <= 1'b0;
      r_end_q     <= 1'b0;
      r_playing   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_hit_q <= bus.i_hit_block;
      r_end_q <= bus.i_endgame;
      unique case (r_state)
        StIdle, StOver: begin
          if (bus.i_start) begin
            r_state     <= StPlay;
            r_score     <= '0;
            r_lives     <= LivesInitBcd;
            r_playing   <= 1'b1;
            r_game_over <= 1'b0;
          end
        end
        StPlay: begin
          // Endgame has priority; a simultaneous hit is dropped.
          if (w_end_rise) begin
            r_lives <= w_lives_dec;
            if (w_lives_dec == '0) begin
              r_state     <= StOver;
              r_playing   <= 1'b0;
              r_game_over <= 1'b1;
              if (bcd_gt(r_score, r_hi, int'(SCORE_DIGITS))) r_hi <= r_score;
            end
          end else if (w_hit_rise) begin
            r_score <= w_inc.value;
            if (BonusEn && w_inc.carry_in[BonusIdx]) r_lives <= w_lives_inc;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_playing   <= 1'b0;
          r_game_over <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_playing   = r_playing;
  assign bus.o_game_over = r_game_over;

  // Display path: choose score or high score, then blank leading zeros above digit 0.
  bcd_num_t                w_disp;
  logic [SCORE_DIGITS-1:0] w_blank;

  assign w_disp = bus.i_show_hi ? r_hi : r_score;

  always_comb begin
    logic nz_above;
    nz_above = 1'b0;
    w_blank  = '0;
    for (int k = 0; k < int'(SCORE_DIGITS) - 1; k++) begin
      int i;
      i = int'(SCORE_DIGITS) - 1 - k;
      if (w_disp[i] != 4'd0) nz_above = 1'b1;
      w_blank[i] = ~nz_above;
    end
  end

  for (genvar g = 0; g < SCORE_DIGITS; g++) begin : gen_score_digit
    seg7_digit u_seg (
      .i_digit (w_disp[g]),
      .i_blank (w_blank[g]),
      .o_seg   (bus.o_score_seg[7*g +: 7])
    );
  end

  seg7_digit u_lives_units (
    .i_digit (r_lives[0]),
    .i_blank (1'b0),
    .o_seg   (bus.o_lives_seg[6:0])
  );

  seg7_digit u_lives_tens (
    .i_digit (r_lives[1]),
    .i_blank (r_lives[1] == 4'd0),
    .o_seg   (bus.o_lives_seg[13:7])
  );

  // Upper digits beyond SCORE_DIGITS and spare increment fields are intentionally unused.
  logic w_unused_bits;
  assign w_unused_bits = ^{w_disp, w_inc};

endmodule

// File: tb/tb_placar_bcd.sv
// Directed self-checking bench for placar_bcd (LIVES_MAX=11 to exercise bonus saturation).
module tb_placar_bcd;
  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  placar_bcd_if #(.SCORE_DIGITS(3)) bus ();

  placar_bcd #(
    .SCORE_DIGITS (3),
    .LIVES_INIT   (10),
    .LIVES_MAX    (11),
    .BONUS_DIGIT  (2)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [20:0] exp_score(input int v);
    logic [20:0] r;
    r[6:0]   = seg_of(v % 10);
    r[13:7]  = (v >= 10)  ? seg_of((v / 10) % 10) : 7'h7F;
    r[20:14] = (v >= 100) ? seg_of(v / 100) : 7'h7F;
    return r;
  endfunction

  function automatic logic [13:0] exp_lives(input int v);
    logic [13:0] r;
    r[6:0]  = seg_of(v % 10);
    r[13:7] = (v >= 10) ? seg_of(v / 10) : 7'h7F;
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hit_pulse(input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_hit_block = 1'b1;
      tick();
      bus.i_hit_block = 1'b0;
      tick();
    end
  endtask

  task automatic end_pulse(input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_endgame = 1'b1;
      tick();
      bus.i_endgame = 1'b0;
      tick();
    end
  endtask

  task automatic start_game();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic check_hi(input string tag, input int v);
    bus.i_show_hi = 1'b1;
    #1;
    check_eq(tag, 32'(bus.o_score_seg), 32'(exp_score(v)));
    bus.i_show_hi = 1'b0;
    #1;
  endtask

  initial begin
    n_total         = 0;
    n_bad           = 0;
    rst             = 1'b1;
    bus.i_start     = 1'b0;
    bus.i_hit_block = 1'b0;
    bus.i_endgame   = 1'b0;
    bus.i_show_hi   = 1'b0;
    tick();
    tick();
    check_eq("rst_score", 32'(bus.o_score_seg), 32'(exp_score(0)));
    check_eq("rst_lives", 32'(bus.o_lives_seg), 32'(exp_lives(10)));
    check_eq("rst_playing", 32'(bus.o_playing), 32'd0);
    check_eq("rst_over", 32'(bus.o_game_over), 32'd0);
    rst = 1'b0;

    // Hits while idle are ignored.
    hit_pulse(1);
    check_eq("idle_hit", 32'(bus.o_score_seg), 32'(exp_score(0)));

    // Game 1
    start_game();
    check_eq("g1_playing", 32'(bus.o_playing), 32'd1);
    hit_pulse(12);
    check_eq("g1_score12", 32'(bus.o_score_seg), 32'(exp_score(12)));
    check_eq("g1_lives10", 32'(bus.o_lives_seg), 32'(exp_lives(10)));
    bus.i_hit_block = 1'b1;
    repeat (50) tick();
    bus.i_hit_block = 1'b0;
    tick();
    check_eq("hold_hit", 32'(bus.o_score_seg), 32'(exp_score(13)));
    start_game();
    check_eq("start_in_play", 32'(bus.o_score_seg), 32'(exp_score(13)));
    hit_pulse(24);
    check_eq("g1_score37", 32'(bus.o_score_seg), 32'(exp_score(37)));
    end_pulse(9);
    check_eq("g1_lives1", 32'(bus.o_lives_seg), 32'(exp_lives(1)));
    check_eq("g1_still_play", 32'(bus.o_playing), 32'd1);
    end_pulse(1);
    check_eq("g1_over", 32'(bus.o_game_over), 32'd1);
    check_eq("g1_not_play", 32'(bus.o_playing), 32'd0);
    hit_pulse(2);
    check_eq("g1_frozen", 32'(bus.o_score_seg), 32'(exp_score(37)));
    check_hi("g1_hi37", 37);

    // Game 2: simultaneous hit+endgame, lower final score
    start_game();
    check_eq("g2_score0", 32'(bus.o_score_seg), 32'(exp_score(0)));
    check_eq("g2_lives10", 32'(bus.o_lives_seg), 32'(exp_lives(10)));
    check_eq("g2_over_clr", 32'(bus.o_game_over), 32'd0);
    check_hi("g2_hi_kept", 37);
    hit_pulse(5);
    end_pulse(7);
    check_eq("g2_lives3", 32'(bus.o_lives_seg), 32'(exp_lives(3)));
    bus.i_hit_block = 1'b1;
    bus.i_endgame   = 1'b1;
    tick();
    bus.i_hit_block = 1'b0;
    bus.i_endgame   = 1'b0;
    tick();
    check_eq("both_score", 32'(bus.o_score_seg), 32'(exp_score(5)));
    check_eq("both_lives", 32'(bus.o_lives_seg), 32'(exp_lives(2)));
    hit_pulse(15);
    end_pulse(2);
    check_eq("g2_over", 32'(bus.o_game_over), 32'd1);
    check_eq("g2_score20", 32'(bus.o_score_seg), 32'(exp_score(20)));
    check_hi("g2_hi37", 37);

    // Game 3: bonus life, saturation of lives, reset mid-play
    start_game();
    hit_pulse(99);
    check_eq("g3_score99", 32'(bus.o_score_seg), 32'(exp_score(99)));
    check_eq("g3_lives10", 32'(bus.o_lives_seg), 32'(exp_lives(10)));
    bus.i_hit_block = 1'b1;
    tick();
    check_eq("bonus_score", 32'(bus.o_score_seg), 32'(exp_score(100)));
    check_eq("bonus_lives", 32'(bus.o_lives_seg), 32'(exp_lives(11)));
    bus.i_hit_block = 1'b0;
    tick();
    hit_pulse(100);
    check_eq("g3_score200", 32'(bus.o_score_seg), 32'(exp_score(200)));
    check_eq("bonus_sat", 32'(bus.o_lives_seg), 32'(exp_lives(11)));
    hit_pulse(250);
    check_eq("g3_score450", 32'(bus.o_score_seg), 32'(exp_score(450)));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_play", 32'(bus.o_playing), 32'd0);
    check_eq("mid_rst_over", 32'(bus.o_game_over), 32'd0);
    check_eq("mid_rst_score", 32'(bus.o_score_seg), 32'(exp_score(0)));
    check_eq("mid_rst_lives", 32'(bus.o_lives_seg), 32'(exp_lives(10)));
    check_hi("mid_rst_hi", 0);

    // Game 4: score saturation at 999
    start_game();
    hit_pulse(999);
    check_eq("g4_score999", 32'(bus.o_score_seg), 32'(exp_score(999)));
    hit_pulse(1);
    check_eq("score_sat", 32'(bus.o_score_seg), 32'(exp_score(999)));
    check_eq("g4_lives", 32'(bus.o_lives_seg), 32'(exp_lives(11)));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/placar_bcd.md
PLACAR_BCD -- requirements
Module: placar_bcd

Interface
REQ-001 Parameter SCORE_DIGITS, default 3: number of BCD score digits, legal range 2..6.
REQ-002 Parameter LIVES_INIT, default 10: lives loaded at reset and on a new game, legal range 1..LIVES_MAX.
REQ-003 Parameter LIVES_MAX, default 99: lives saturation ceiling, legal range 1..99.
REQ-004 Parameter BONUS_DIGIT, default 2: a carry into score digit BONUS_DIGIT awards one life (2 gives one life per 100 points); 0 disables bonus lives.
REQ-005 clock  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  level; request a new game.
REQ-008 hit_block  in  1  level; ball touching a block, counted once per rising edge.
REQ-009 endgame  in  1  level; ball lost, counted once per rising edge.
REQ-010 show_hi  in  1  1 = score_seg displays the high score instead of the current score.
REQ-011 score_seg  out  7*SCORE_DIGITS  segment code per digit, digit 0 (units) in bits [6:0], active-low, 7'h7F = blank.
REQ-012 lives_seg  out  14  two lives digits, units in [6:0], same encoding.
REQ-013 playing  out  1  high in state PLAY.
REQ-014 game_over  out  1  high in state OVER.

Function
REQ-015 The block SHALL register hit_block and endgame every cycle, in every state, and derive rise = input & ~registered_input.
REQ-016 The FSM SHALL have three states: IDLE, PLAY and OVER.
REQ-017 IDLE->PLAY on start; OVER->PLAY on start; PLAY->OVER when a lives decrement reaches 0; start in PLAY SHALL be ignored.
REQ-018 On any entry to PLAY, the block SHALL clear the score to 0 and reload lives to LIVES_INIT.
REQ-019 In PLAY, a hit rise SHALL add 1 to the score as a BCD ripple increment, visible on the next edge (1-cycle latency from the first high sample).
REQ-020 The score SHALL saturate at all nines (999 for 3 digits) with no wrap.
REQ-021 When an increment carries into digit BONUS_DIGIT (BONUS_DIGIT>0), the block SHALL increment lives in the same cycle, saturating at LIVES_MAX.
REQ-022 In PLAY, an endgame rise SHALL decrement lives in BCD.
REQ-023 If that endgame decrement yields 0, the block SHALL enter OVER and leave the score frozen.
REQ-024 If an endgame rise and a hit rise occur in the same cycle, the endgame rise SHALL win and the hit SHALL be discarded.
REQ-025 Hit and endgame rises in IDLE or OVER SHALL have no effect.
REQ-026 On the PLAY->OVER transition, the high score SHALL be replaced by the score if the score is strictly greater (digit-wise BCD compare, MSD first).
REQ-027 The high score SHALL persist across games and be cleared only by reset.
REQ-028 Leading-zero blanking: any digit above the most-significant nonzero digit SHALL show 7'h7F; digit 0 SHALL always be shown (value 0 shows "0").
REQ-029 Segment outputs SHALL be combinational decodes of registered BCD values.
REQ-030 playing and game_over SHALL be registered state decodes.

Reset
REQ-031 While reset is high, the block SHALL force state=IDLE, score=0, high score=0, lives=LIVES_INIT and both edge registers=0.
REQ-032 Reset during PLAY SHALL abort the game with no high-score update.
REQ-033 At reset, outputs SHALL be: score_seg units "0" with all others blank, lives_seg showing LIVES_INIT, playing=0, game_over=0.
REQ-034 Reset SHALL have priority over all other inputs.

Structure
REQ-035 Shared package placar_pkg SHALL hold the state enum, SEG_BLANK=7'h7F, and the BCD-digit typedef (4 bits).
REQ-036 The block SHALL instantiate one sub-module, seg7_digit (4-bit BCD plus blank in, 7-bit active-low segments out), once per displayed digit.
REQ-037 BCD increment, decrement and compare SHALL be functions in placar_pkg; no binary-to-BCD converter is used.

Verification
REQ-038 Reset, then start, then 12 single-cycle hit pulses -> score_seg shows "12" with hundreds blanked; lives_seg shows "10".
REQ-039 hit_block held high for 50 cycles in PLAY -> score increments by exactly 1.
REQ-040 Score 099 plus one hit -> score "100" and lives 10->11 in the same cycle; with LIVES_MAX=11, a second bonus leaves lives at 11.
REQ-041 Hit rise and endgame rise in the same cycle at score 5, lives 3 -> score 5, lives 2.
REQ-042 Ten endgame pulses from lives 10 at score 37 -> game_over=1, high score 37, score frozen; a later game ending at 20 leaves high score 37 (checked via show_hi=1).
REQ-043 Reset asserted mid-PLAY at score 450 -> next cycle IDLE, score "0", high score "0", lives "10".
